// File: rtl/ahb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_responder
//  Purpose  : AHB-Lite subordinate terminating the main-bus side of the
//             manager fabric. It is backed by a word-addressed SRAM with
//             byte-lane writes. Read and write data phases can be given a
//             programmable number of wait states. Illegal transfers receive
//             the two-cycle ERROR response.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_hclk       in   1           bus clock, rising edge
//    i_hreset     in   1           asynchronous active-low reset
//    i_hsel       in   1           subordinate select from the decoder
//    i_haddr      in   ADDR_WIDTH  byte address (address phase)
//    i_hwrite     in   1           1 = write, 0 = read
//    i_hsize      in   3           0 = byte, 1 = half, 2 = word, >2 illegal
//    i_htrans     in   2           IDLE / BUSY / NONSEQ / SEQ
//    i_hburst     in   3           burst type, informational only
//    i_hreadyin   in   1           bus-level HREADY
//    i_hwdata     in   DATA_WIDTH  write data (data phase)
//    o_hreadyout  out  1           0 = extend the current data phase
//    o_hresp      out  1           0 = OKAY, 1 = ERROR
//    o_hrdata     out  DATA_WIDTH  read data
// ============================================================================
module ahb_sram_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 512,
    parameter int WAIT_WRITE   = 0,
    parameter int WAIT_READ    = 0
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [1:0]            i_htrans,
    input  logic [2:0]            i_hburst,
    input  logic                  i_hreadyin,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The data path has a fixed width of 32 bits, so there are always four byte lanes.
    localparam int c_LANES    = 4;
    localparam int c_IDX_W    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int c_WAIT_MAX = (WAIT_WRITE > WAIT_READ) ? WAIT_WRITE : WAIT_READ;
    localparam int c_CNT_W    = (c_WAIT_MAX > 1) ? $clog2(c_WAIT_MAX + 1) : 1;

    localparam logic [c_CNT_W-1:0]    c_N_WR  = c_CNT_W'(WAIT_WRITE);
    localparam logic [c_CNT_W-1:0]    c_N_RD  = c_CNT_W'(WAIT_READ);
    localparam logic [c_CNT_W-1:0]    c_ONE   = c_CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH = ADDR_WIDTH'(MEMORY_DEPTH);

    // ------------------------------------------------------------------------
    // Data-phase state machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // single-cycle OKAY / final cycle of a wait-state phase
        S_WAIT = 2'd1,   // hreadyout held low for the programmed wait count
        S_ERR1 = 2'd2,   // first ERROR cycle (hreadyout low)
        S_ERR2 = 2'd3    // second ERROR cycle (hreadyout high)
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    // ------------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------------
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_bad_range;
    logic                 w_bad_size;
    logic                 w_bad_align;
    logic                 w_illegal;
    logic                 w_legal_acc;
    logic [c_CNT_W-1:0]   w_n;
    logic [c_LANES-1:0]   w_be;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_unused;

    // The final cycle of a data phase occurs in S_IDLE or S_ERR2. These are the
    // only cycles in which a new address phase can be accepted.
    assign w_ready  = (r_state == S_IDLE) || (r_state == S_ERR2);
    assign w_accept = i_hsel & i_hreadyin & i_htrans[1] & w_ready;

    assign w_bad_range = {2'b00, i_haddr[ADDR_WIDTH-1:2]} >= c_DEPTH;
    assign w_bad_size  = i_hsize[2] | (i_hsize[1] & i_hsize[0]);
    assign w_bad_align = ((i_hsize == 3'd1) & i_haddr[0]) |
                         ((i_hsize == 3'd2) & (i_haddr[1:0] != 2'b00));
    assign w_illegal   = w_bad_range | w_bad_size | w_bad_align;
    assign w_legal_acc = w_accept & ~w_illegal;

    assign w_n   = i_hwrite ? c_N_WR : c_N_RD;
    assign w_idx = i_haddr[c_IDX_W+1:2];

    // The burst type has no effect on the response. Each beat is handled on its own.
    assign w_unused = ^{i_hburst, 1'b0};

    // Byte-lane enables for the transfer being accepted.
    always_comb begin
        w_be = 4'b0000;
        case (i_hsize)
            3'd0:    w_be = 4'b0001 << i_haddr[1:0];
            3'd1:    w_be = i_haddr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and bus response
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_hreadyout = w_ready;
        o_hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);

        case (r_state)
            S_IDLE, S_ERR2: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    if (w_illegal) begin
                        w_state_nxt = S_ERR1;
                    end else if (w_n != '0) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = w_n;
                    end
                end
            end
            S_WAIT: begin
                // The counter holds the number of low cycles left, including
                // the current one. When it reaches 1, the next cycle is the high one.
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR1: begin
                w_state_nxt = S_ERR2;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Data-phase bookkeeping
    // ------------------------------------------------------------------------
    logic                 r_wr_pend;
    logic                 r_rd_pend;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_LANES-1:0]   r_be;
    logic [DATA_WIDTH-1:0] r_hrdata;

    logic                 w_commit;
    logic                 w_fwd_hit;
    logic                 w_rd_now;
    logic                 w_rd_late;
    logic [DATA_WIDTH-1:0] w_mem_acc;   // word at the address-phase index
    logic [DATA_WIDTH-1:0] w_mem_dp;    // word at the data-phase index
    logic [DATA_WIDTH-1:0] w_fwd_word;  // w_mem_acc merged with a committing write

    // A write is committed on the edge that ends its data phase, because
    // that is the edge at which i_hwdata is known to be valid.
    assign w_commit  = r_wr_pend & w_ready;
    assign w_fwd_hit = w_commit & (r_idx == w_idx);

    // A zero-wait read samples the array on its address-phase edge. A read
    // with wait states samples the array on the edge before its final cycle.
    // By then, any earlier write has already reached the array.
    assign w_rd_now  = w_legal_acc & ~i_hwrite & (c_N_RD == '0);
    assign w_rd_late = (r_state == S_WAIT) & (r_cnt == c_ONE) & r_rd_pend;

    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_idx     <= '0;
            r_be      <= '0;
            r_hrdata  <= '0;
        end else begin
            if (w_ready) begin
                r_wr_pend <= w_legal_acc & i_hwrite;
                r_rd_pend <= w_legal_acc & ~i_hwrite;
                if (w_legal_acc) begin
                    r_idx <= w_idx;
                    r_be  <= w_be;
                end
            end
            // During an ERROR response and idle cycles, the last read value is held.
            if (w_rd_now) begin
                r_hrdata <= w_fwd_word;
            end else if (w_rd_late) begin
                r_hrdata <= w_mem_dp;
            end
        end
    end

    assign o_hrdata = r_hrdata;

    // ------------------------------------------------------------------------
    // Byte-lane SRAM (contents are not reset)
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < c_LANES; g++) begin : g_lane
        logic [7:0] r_lane_mem [MEMORY_DEPTH];

        always_ff @(posedge i_hclk) begin
            if (w_commit && r_be[g]) begin
                r_lane_mem[r_idx] <= i_hwdata[8*g +: 8];
            end
        end

        assign w_mem_acc[8*g +: 8] = r_lane_mem[w_idx];
        assign w_mem_dp[8*g +: 8]  = r_lane_mem[r_idx];

        // This is write-to-read forwarding. When a read is accepted in the final
        // cycle of a write to the same word, the array does not yet hold the new
        // bytes. In that case the bytes are taken from the bus.
        assign w_fwd_word[8*g +: 8] = (w_fwd_hit && r_be[g]) ? i_hwdata[8*g +: 8]
                                                             : w_mem_acc[8*g +: 8];
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_sram_responder
//  Purpose  : Self-checking bench for ahb_sram_responder. It has two
//             instances: dut0 has no wait states, and dut1 has 1 write wait
//             and 2 read waits. They share one bus, and a select bit steers
//             hsel and the HREADY/HRESP/HRDATA return mux. The driver pushes
//             the expected response for each tracked address phase into a
//             queue. A monitor pops that queue and checks each data phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_responder;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_NSEQ = 2'd2;
    localparam logic [1:0] c_SEQ  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel;
    logic        hsel_bus;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        trk;

    logic        hsel0, hsel1;
    logic        ready0, ready1, resp0, resp1;
    logic [31:0] rdata0, rdata1;
    logic        w_hready, w_hresp;
    logic [31:0] w_hrdata;

    always #5 clk = ~clk;

    assign hsel0    = hsel_bus & ~sel;
    assign hsel1    = hsel_bus & sel;
    assign w_hready = sel ? ready1 : ready0;
    assign w_hresp  = sel ? resp1  : resp0;
    assign w_hrdata = sel ? rdata1 : rdata0;

    ahb_sram_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEMORY_DEPTH(512),
        .WAIT_WRITE(0), .WAIT_READ(0)
    ) dut0 (
        .i_hclk(clk), .i_hreset(rst_n), .i_hsel(hsel0), .i_haddr(haddr),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_htrans(htrans), .i_hburst(hburst),
        .i_hreadyin(w_hready), .i_hwdata(hwdata),
        .o_hreadyout(ready0), .o_hresp(resp0), .o_hrdata(rdata0)
    );

    ahb_sram_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEMORY_DEPTH(512),
        .WAIT_WRITE(1), .WAIT_READ(2)
    ) dut1 (
        .i_hclk(clk), .i_hreset(rst_n), .i_hsel(hsel1), .i_haddr(haddr),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_htrans(htrans), .i_hburst(hburst),
        .i_hreadyin(w_hready), .i_hwdata(hwdata),
        .o_hreadyout(ready1), .o_hresp(resp1), .o_hrdata(rdata1)
    );

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] waits;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] next_wd = 32'h0;
    bit          in_dp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %08h, required %08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: on every negedge, evaluate the data phase in progress. Then,
    // if a tracked address phase is being accepted, open its data phase.
    initial begin : monitor
        exp_t cur;
        int   waits;
        logic resp_bad;
        cur = '0;
        waits = 0;
        resp_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_dp = 1'b0;
            end else begin
                if (in_dp) begin
                    if (!w_hready) begin
                        waits++;
                        if (w_hresp !== cur.err) resp_bad = 1'b1;
                        if (waits > 16) begin
                            check("wait_timeout", 32'(waits), cur.waits);
                            in_dp = 1'b0;
                        end
                    end else begin
                        check("wait_cycles", 32'(waits), cur.waits);
                        check("resp_in_wait", {31'b0, resp_bad}, 32'd0);
                        check("resp_final", {31'b0, w_hresp}, {31'b0, cur.err});
                        if (cur.chk) check("rdata", w_hrdata, cur.data);
                        in_dp = 1'b0;
                    end
                end
                if (!in_dp && trk && w_hready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL scoreboard: actual empty queue, required an expected entry");
                    end else begin
                        cur = exp_q.pop_front();
                        in_dp = 1'b1;
                        waits = 0;
                        resp_bad = 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    // Holds the address phase until a posedge where bus HREADY is high.
    task automatic wait_accept();
        logic rdy;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            rdy = w_hready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: actual hready=0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic xfer(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                        input logic [2:0] sz, input logic [31:0] wd, input logic e,
                        input int nw, input logic ck, input logic [31:0] d);
        exp_t x;
        hsel_bus = 1'b1;
        htrans   = tr;
        haddr    = a;
        hwrite   = wr;
        hsize    = sz;
        hwdata   = next_wd;
        trk      = 1'b1;
        x.err    = e;
        x.chk    = ck;
        x.waits  = 32'(nw);
        x.data   = d;
        exp_q.push_back(x);
        wait_accept();
        next_wd  = wd;
    endtask

    task automatic idle();
        htrans = c_IDLE;
        trk    = 1'b0;
        hwdata = next_wd;
        wait_accept();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_dp) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: actual %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        sel = 1'b0; hsel_bus = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
        htrans = c_IDLE; hburst = 3'd0; hwdata = '0; trk = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", {31'b0, ready0}, 32'd1);
        check("rst_resp0",  {31'b0, resp0},  32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_ready1", {31'b0, ready1}, 32'd1);
        check("rst_resp1",  {31'b0, resp1},  32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- dut0: zero wait states ----
        sel = 1'b0;
        xfer(c_NSEQ, 32'h10, 1, 3'd2, 32'hDEADBEEF, 0, 0, 0, 32'h0);
        xfer(c_NSEQ, 32'h10, 0, 3'd2, 32'h0,        0, 0, 1, 32'hDEADBEEF);
        xfer(c_NSEQ, 32'h20, 1, 3'd2, 32'h00000000, 0, 0, 0, 32'h0);
        xfer(c_NSEQ, 32'h21, 1, 3'd0, 32'hAABB11CC, 0, 0, 0, 32'h0);
        xfer(c_NSEQ, 32'h20, 0, 3'd2, 32'h0,        0, 0, 1, 32'h00001100);
        xfer(c_NSEQ, 32'h22, 1, 3'd1, 32'hBEEF7777, 0, 0, 0, 32'h0);
        xfer(c_NSEQ, 32'h00, 1, 3'd2, 32'h01020304, 0, 0, 0, 32'h0);
        xfer(c_NSEQ, 32'h23, 0, 3'd0, 32'h0,        0, 0, 1, 32'hBEEF1100);
        // Illegal transfers: out of range, misaligned half, misaligned word, size 3
        xfer(c_NSEQ, 32'h800, 0, 3'd2, 32'h0,        1, 1, 1, 32'hBEEF1100);
        xfer(c_NSEQ, 32'h01,  1, 3'd1, 32'h5555AAAA, 1, 1, 1, 32'hBEEF1100);
        xfer(c_IDLE, 32'h00,  0, 3'd2, 32'h0,        0, 0, 0, 32'h0);
        xfer(c_NSEQ, 32'h00,  0, 3'd2, 32'h0,        0, 0, 1, 32'h01020304);
        xfer(c_NSEQ, 32'h12,  0, 3'd2, 32'h0,        1, 1, 1, 32'h01020304);
        xfer(c_NSEQ, 32'h10,  0, 3'd3, 32'h0,        1, 1, 1, 32'h01020304);
        xfer(c_NSEQ, 32'h10,  0, 3'd2, 32'h0,        0, 0, 1, 32'hDEADBEEF);
        xfer(c_NSEQ, 32'h13,  1, 3'd0, 32'h99000000, 0, 0, 0, 32'h0);
        xfer(c_NSEQ, 32'h10,  0, 3'd2, 32'h0,        0, 0, 1, 32'h99ADBEEF);
        idle();
        drain();

        // ---- dut1: WAIT_WRITE=1, WAIT_READ=2 ----
        sel = 1'b1;
        xfer(c_NSEQ, 32'h10, 1, 3'd2, 32'hDEADBEEF, 0, 1, 0, 32'h0);
        xfer(c_NSEQ, 32'h10, 0, 3'd2, 32'h0,        0, 2, 1, 32'hDEADBEEF);
        xfer(c_NSEQ, 32'h11, 1, 3'd0, 32'h00004200, 0, 1, 0, 32'h0);
        xfer(c_NSEQ, 32'h10, 0, 3'd2, 32'h0,        0, 2, 1, 32'hDEAD42EF);
        // INCR4 write burst with a BUSY after beat 2, then read back
        hburst = 3'd3;
        xfer(c_NSEQ, 32'h40, 1, 3'd2, 32'd1, 0, 1, 0, 32'h0);
        xfer(c_SEQ,  32'h44, 1, 3'd2, 32'd2, 0, 1, 0, 32'h0);
        xfer(c_BUSY, 32'h48, 1, 3'd2, 32'd0, 0, 0, 0, 32'h0);
        xfer(c_SEQ,  32'h48, 1, 3'd2, 32'd3, 0, 1, 0, 32'h0);
        xfer(c_SEQ,  32'h4C, 1, 3'd2, 32'd4, 0, 1, 0, 32'h0);
        xfer(c_NSEQ, 32'h40, 0, 3'd2, 32'h0, 0, 2, 1, 32'd1);
        xfer(c_SEQ,  32'h44, 0, 3'd2, 32'h0, 0, 2, 1, 32'd2);
        xfer(c_SEQ,  32'h48, 0, 3'd2, 32'h0, 0, 2, 1, 32'd3);
        xfer(c_SEQ,  32'h4C, 0, 3'd2, 32'h0, 0, 2, 1, 32'd4);
        hburst = 3'd0;
        xfer(c_NSEQ, 32'h800, 0, 3'd2, 32'h0, 1, 1, 1, 32'd4);
        xfer(c_IDLE, 32'h0,   0, 3'd2, 32'h0, 0, 0, 0, 32'h0);
        // Set up a word for the reset test
        xfer(c_NSEQ, 32'h30, 1, 3'd2, 32'hA5A5A5A5, 0, 1, 0, 32'h0);
        xfer(c_NSEQ, 32'h30, 0, 3'd2, 32'h0,        0, 2, 1, 32'hA5A5A5A5);
        idle();
        drain();

        // ---- reset asserted during the wait cycle of an untracked write ----
        hsel_bus = 1'b1; htrans = c_NSEQ; haddr = 32'h30; hwrite = 1'b1;
        hsize = 3'd2; trk = 1'b0; hwdata = 32'h0;
        wait_accept();
        htrans = c_IDLE;
        hwdata = 32'h12345678;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready1}, 32'd1);
        check("midrst_resp",  {31'b0, resp1},  32'd0);
        check("midrst_rdata", rdata1, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        next_wd = 32'h0;
        xfer(c_NSEQ, 32'h30, 0, 3'd2, 32'h0, 0, 2, 1, 32'hA5A5A5A5);
        idle();
        drain();

        // dut0 memory survives reset
        sel = 1'b0;
        xfer(c_NSEQ, 32'h10, 0, 3'd2, 32'h0, 0, 0, 1, 32'h99ADBEEF);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
